// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with 2-entry skid buffer and masked flush
// Ports: clk, i_rst (sync, active-high), i_en (freeze when low), i_flush (kill entries),
//        i_valid/o_ready/i_fields (upstream), o_valid/i_ready/o_fields (downstream), o_count (0..2)
module pipe_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FIELDS = 5,
  parameter logic [NUM_FIELDS-1:0] FLUSH_MASK = 1
) (
  input  logic                             clk,
  input  logic                             i_rst,
  input  logic                             i_en,
  input  logic                             i_flush,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] i_fields,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] o_fields,
  output logic [1:0]                       o_count
);
  localparam int W = NUM_FIELDS * DATA_WIDTH;
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
  state_t state;
  logic rdy_q, in_fire, out_fire;
  logic [W-1:0] main_q, skid_q, keep;
  // keep has ones in every field that survives a flush
  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_keep
    assign keep[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{~FLUSH_MASK[k]}};
  end
  assign o_ready  = rdy_q & i_en;
  assign o_valid  = (state != EMPTY) & i_en;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;
  assign o_fields = main_q;
  assign o_count  = state;
  // handshakes are already gated by i_en, so a low i_en leaves every branch idle
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b0;
    end else if (i_flush) begin
      state  <= EMPTY;
      main_q <= main_q & keep;
      skid_q <= skid_q & keep;
      rdy_q  <= 1'b1;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        EMPTY: if (in_fire) begin
          main_q <= i_fields;
          state  <= FULL;
        end
        FULL: if (in_fire && out_fire) main_q <= i_fields;
          else if (in_fire) begin
            skid_q <= i_fields;
            state  <= SKID;
            rdy_q  <= 1'b0;
          end else if (out_fire) state <= EMPTY;
        SKID: if (out_fire) begin
          main_q <= skid_q;
          state  <= FULL;
        end else rdy_q <= 1'b0;
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg plus a random scoreboard on a narrow instance
module tb_pipe_stage_reg;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, en, flush, valid, ready, ordy, ovalid;
  logic [159:0] din, dout;
  logic [1:0] cnt;
  logic p_en, p_flush, p_valid, p_ready, p_ordy, p_ovalid;
  logic [15:0] p_din, p_dout;
  logic [1:0] p_cnt;
  int errors = 0, checks = 0;
  pipe_stage_reg u (
    .clk(clk), .i_rst(rst), .i_en(en), .i_flush(flush), .i_valid(valid), .o_ready(ordy),
    .i_fields(din), .o_valid(ovalid), .i_ready(ready), .o_fields(dout), .o_count(cnt)
  );
  pipe_stage_reg #(.DATA_WIDTH(8), .NUM_FIELDS(2), .FLUSH_MASK(2'b11)) p (
    .clk(clk), .i_rst(rst), .i_en(p_en), .i_flush(p_flush), .i_valid(p_valid), .o_ready(p_ordy),
    .i_fields(p_din), .o_valid(p_ovalid), .i_ready(p_ready), .o_fields(p_dout), .o_count(p_cnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [159:0] w(input logic [31:0] f0, input logic [31:0] f1);
    return {96'd0, f1, f0};
  endfunction
  initial begin
    logic [15:0] q[$];
    logic [15:0] d;
    bit inf, outf;
    rst = 1; en = 1; flush = 0; valid = 0; ready = 0; din = '0;
    p_en = 1; p_flush = 0; p_valid = 0; p_ready = 0; p_din = '0;
    tick(); tick();
    chk("rst_fields", dout, '0);
    chk("rst_valid", ovalid, 0);
    chk("rst_count", cnt, 0);
    chk("rst_ready_low", ordy, 0);
    rst = 0;
    tick();
    chk("rst_ready_after", ordy, 1);
    valid = 1; ready = 1;
    for (int i = 1; i <= 4; i++) begin
      din = w(i, 0);
      tick();
      chk("stream_f0", dout[31:0], i);
      chk("stream_valid", ovalid, 1);
      chk("stream_count", cnt, 1);
      chk("stream_ready", ordy, 1);
    end
    valid = 0;
    tick();
    chk("stream_drain", cnt, 0);
    ready = 0; valid = 1; din = w(32'hA, 0);
    tick();
    chk("bp_a_count", cnt, 1);
    chk("bp_a_ready", ordy, 1);
    din = w(32'hB, 0);
    tick();
    chk("bp_b_count", cnt, 2);
    chk("bp_b_ready", ordy, 0);
    chk("bp_b_head", dout[31:0], 32'hA);
    din = w(32'hC, 0);
    tick();
    chk("bp_c_held", cnt, 2);
    chk("bp_c_head", dout[31:0], 32'hA);
    ready = 1;
    tick();
    chk("bp_out_b", dout[31:0], 32'hB);
    chk("bp_out_b_count", cnt, 1);
    chk("bp_ready_back", ordy, 1);
    tick();
    chk("bp_out_c", dout[31:0], 32'hC);
    valid = 0;
    tick();
    chk("bp_empty", cnt, 0);
    ready = 0; valid = 1; din = w(32'hFFFF_FFFF, 32'h1234);
    tick(); tick();
    chk("fl_two", cnt, 2);
    flush = 1; din = w(32'h55, 32'h99);
    tick();
    flush = 0; valid = 0;
    #1;
    chk("fl_valid", ovalid, 0);
    chk("fl_count", cnt, 0);
    chk("fl_ready", ordy, 1);
    chk("fl_f0", dout[31:0], 0);
    chk("fl_f1", dout[63:32], 32'h1234);
    tick();
    chk("fl_no_ghost", ovalid, 0);
    ready = 1; valid = 1; din = w(32'h10, 0);
    tick();
    en = 0; din = w(32'h11, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_ready", ordy, 0);
      chk("en_valid", ovalid, 0);
      chk("en_f0", dout[31:0], 32'h10);
      chk("en_count", cnt, 1);
    end
    en = 1;
    #1;
    chk("en_resume_head", dout[31:0], 32'h10);
    chk("en_resume_valid", ovalid, 1);
    tick();
    chk("en_resume_next", dout[31:0], 32'h11);
    chk("en_resume_count", cnt, 1);
    valid = 0;
    tick();
    ready = 0; valid = 1; din = w(32'h21, 0);
    tick();
    din = w(32'h22, 0);
    tick();
    chk("rs_skid", cnt, 2);
    rst = 1; valid = 0;
    tick();
    rst = 0;
    #1;
    chk("rs_fields", dout, '0);
    chk("rs_valid", ovalid, 0);
    chk("rs_count", cnt, 0);
    tick();
    chk("rs_ready", ordy, 1);
    for (int c = 0; c < 3000; c++) begin
      p_valid = ($urandom_range(0, 9) < 7);
      p_ready = ($urandom_range(0, 9) < 6);
      p_din = 16'($urandom);
      #1;
      inf = p_valid & p_ordy;
      outf = p_ovalid & p_ready;
      chk("sw_count", p_cnt, q.size());
      if (outf) begin
        d = (q.size() != 0) ? q.pop_front() : 16'hxxxx;
        chk("sw_data", p_dout, d);
      end
      if (inf) q.push_back(p_din);
      tick();
    end
    p_flush = 1; p_valid = 0;
    tick();
    p_flush = 0; p_valid = 1; p_ready = 0; p_din = 16'hBEEF;
    tick();
    chk("sw_load", p_dout, 16'hBEEF);
    p_valid = 0; p_flush = 1;
    tick();
    p_flush = 0;
    chk("sw_flush_data", p_dout, 0);
    chk("sw_flush_count", p_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
